fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_VECTOR, default 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter NOP_WORD, default 32'h0000_0013, IR value loaded on reset (addi x0,x0,0).
REQ-003 fetch_unit_clock_in  input  1  single clock; all state updates on posedge.
REQ-004 fetch_unit_reset_in  input  1  reset, asynchronous, active-high.
REQ-005 fetch_unit_pc_set_val_in  input  1  from control unit; load PC with next-PC mux result.
REQ-006 fetch_unit_ir_set_val_in  input  1  from control unit; start instruction fetch into IR.
REQ-007 fetch_unit_pc_mux_sel_in  input  2  next-PC source select.
REQ-008 fetch_unit_branch_target_in  input  32  branch target address.
REQ-009 fetch_unit_jump_target_in  input  32  jump target address.
REQ-010 fetch_unit_pc_out  output  32  current PC.
REQ-011 fetch_unit_ir_out  output  32  current instruction register.
REQ-012 fetch_unit_ins_data_out  output  7  IR[6:0] opcode returned to control unit.
REQ-013 fetch_unit_fetch_done_out  output  1  one-cycle pulse when a fetch completes.
REQ-014 fetch_unit_fetch_err_out  output  1  sticky misaligned-fetch flag.
REQ-015 fetch_unit_mem_req_out / _mem_addr_out  output  1/32  instruction memory request and word address.
REQ-016 fetch_unit_mem_ack_in / _mem_data_in  input  1/32  memory acknowledge and read data, valid together.

Function
REQ-017 Next-PC mux SHALL select: 2'b00 PC+4 (32-bit wrap, 32'hFFFF_FFFC+4 = 0), 2'b01 branch target, 2'b10 jump target, 2'b11 PC (hold).
REQ-018 On posedge with pc_set_val_in=1, PC SHALL take the mux result; otherwise PC SHALL hold.
REQ-019 Fetch FSM states SHALL be IDLE, REQ, DONE.
REQ-020 IDLE: ir_set_val_in=1 with PC[1:0]=2'b00 SHALL latch PC into mem_addr_out and enter REQ next cycle.
REQ-021 IDLE: ir_set_val_in=1 with PC[1:0]!=0 SHALL set fetch_err_out, leave IR unchanged, issue no request, and enter DONE.
REQ-022 REQ: mem_req_out SHALL be 1 and mem_addr_out stable until mem_ack_in=1; wait states unbounded.
REQ-023 REQ with mem_ack_in=1: IR SHALL load mem_data_in on that edge; state goes to DONE.
REQ-024 DONE: fetch_done_out SHALL be 1 for exactly one cycle, mem_req_out 0, then return to IDLE.
REQ-025 mem_req_out SHALL be 0 in IDLE and DONE; mem_ack_in outside REQ SHALL be ignored.
REQ-026 pc_set_val_in and ir_set_val_in on the same edge in IDLE: fetch SHALL use the pre-update PC; PC updates normally.
REQ-027 pc_set_val_in during REQ/DONE SHALL update PC without changing the latched mem_addr_out.
REQ-028 ir_set_val_in while not IDLE SHALL be ignored (no queuing).
REQ-029 ins_data_out SHALL equal IR[6:0] combinationally; minimum fetch latency is issue edge + 1 ack cycle + DONE.
REQ-030 fetch_err_out SHALL clear only on reset.

Reset
REQ-031 Reset assertion SHALL immediately force PC=RESET_VECTOR, IR=NOP_WORD, state=IDLE, mem_req_out=0, mem_addr_out=0, fetch_done_out=0, fetch_err_out=0.
REQ-032 Reset mid-fetch SHALL abandon the transaction; a later mem_ack_in SHALL be ignored.

Structure
REQ-033 Next-PC select encodings, FSM state encodings and NOP_WORD SHALL live in the shared core101 definitions package, also used by the control unit.
REQ-034 The next-PC mux plus PC register SHALL be one sub-module, pc_reg; the fetch FSM stays in fetch_unit.

Verification
REQ-035 Reset release, sel=00, pc_set pulse ×3 -> pc_out 0x0,0x4,0x8,0xC; ir_out=0x00000013, ins_data_out=0x13.
REQ-036 ir_set at PC=0x8, ack after 3 wait cycles with data 0x00A00093 -> req high 3+1 cycles, addr 0x8, ir_out=0x00A00093, done pulse 1 cycle.
REQ-037 Same-edge pc_set (sel=01, branch=0x100) and ir_set at PC=0x10 -> mem_addr_out=0x10, pc_out=0x100.
REQ-038 jump target 0x102, sel=10, pc_set, then ir_set -> no req, fetch_err_out=1, done pulse, IR unchanged.
REQ-039 Reset asserted during REQ, ack pulsed after release -> req drops at once, IR stays 0x00000013, no done pulse.
REQ-040 PC=0xFFFFFFFC, sel=00, pc_set -> pc_out=0x00000000.

Source files
------------

// File: rtl/core101_pkg.sv
// Shared core101 definitions: next-PC select codes, fetch FSM states and
// the reset instruction word, common to the fetch and control units.
package core101_pkg;

   typedef enum logic [1:0] {
      PC_SEL_PLUS4  = 2'b00,
      PC_SEL_BRANCH = 2'b01,
      PC_SEL_JUMP   = 2'b10,
      PC_SEL_HOLD   = 2'b11
   } pc_sel_e;

   typedef enum logic [1:0] {
      FS_IDLE = 2'd0,
      FS_REQ  = 2'd1,
      FS_DONE = 2'd2
   } fetch_state_e;

   // addi x0,x0,0
   localparam logic [31:0] NOP_INSN = 32'h0000_0013;

endpackage

// File: rtl/fetch_unit_pc_reg.sv
// Program counter register with its next-PC source mux.
module pc_reg
   import core101_pkg::*;
#(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        pc_set,
   input  pc_sel_e     pc_sel,
   input  logic [31:0] branch_target,
   input  logic [31:0] jump_target,
   output logic [31:0] pc
);

   logic [31:0] pc_q;
   logic [31:0] pc_d;
   logic [31:0] pc_next;

   always_comb begin
      pc_next = pc_q;
      case (pc_sel)
         PC_SEL_PLUS4:  pc_next = pc_q + 32'd4;
         PC_SEL_BRANCH: pc_next = branch_target;
         PC_SEL_JUMP:   pc_next = jump_target;
         PC_SEL_HOLD:   pc_next = pc_q;
         default:       pc_next = pc_q;
      endcase
      pc_d = pc_set ? pc_next : pc_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) pc_q <= RESET_VECTOR;
      else     pc_q <= pc_d;
   end

   assign pc = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC register plus an IDLE/REQ/DONE fetch FSM that
// reads one word from instruction memory into the IR.
module fetch_unit
   import core101_pkg::*;
#(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
   parameter logic [31:0] NOP_WORD     = core101_pkg::NOP_INSN
) (
   input  logic        fetch_unit_clock_in,
   input  logic        fetch_unit_reset_in,
   input  logic        fetch_unit_pc_set_val_in,
   input  logic        fetch_unit_ir_set_val_in,
   input  logic [1:0]  fetch_unit_pc_mux_sel_in,
   input  logic [31:0] fetch_unit_branch_target_in,
   input  logic [31:0] fetch_unit_jump_target_in,
   output logic [31:0] fetch_unit_pc_out,
   output logic [31:0] fetch_unit_ir_out,
   output logic [6:0]  fetch_unit_ins_data_out,
   output logic        fetch_unit_fetch_done_out,
   output logic        fetch_unit_fetch_err_out,
   output logic        fetch_unit_mem_req_out,
   output logic [31:0] fetch_unit_mem_addr_out,
   input  logic        fetch_unit_mem_ack_in,
   input  logic [31:0] fetch_unit_mem_data_in
);

   fetch_state_e state_q, state_d;
   logic [31:0]  addr_q, addr_d;
   logic [31:0]  ir_q, ir_d;
   logic         err_q, err_d;
   logic [31:0]  pc;

   pc_reg #(
      .RESET_VECTOR(RESET_VECTOR)
   ) u_pc_reg (
      .clk          (fetch_unit_clock_in),
      .rst          (fetch_unit_reset_in),
      .pc_set       (fetch_unit_pc_set_val_in),
      .pc_sel       (pc_sel_e'(fetch_unit_pc_mux_sel_in)),
      .branch_target(fetch_unit_branch_target_in),
      .jump_target  (fetch_unit_jump_target_in),
      .pc           (pc)
   );

   // pc is the registered value, so a same-edge pc_set cannot affect the fetch address
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      ir_d    = ir_q;
      err_d   = err_q;
      case (state_q)
         FS_IDLE: begin
            if (fetch_unit_ir_set_val_in) begin
               if (pc[1:0] == 2'b00) begin
                  addr_d  = pc;
                  state_d = FS_REQ;
               end else begin
                  err_d   = 1'b1;
                  state_d = FS_DONE;
               end
            end
         end
         FS_REQ: begin
            if (fetch_unit_mem_ack_in) begin
               ir_d    = fetch_unit_mem_data_in;
               state_d = FS_DONE;
            end
         end
         FS_DONE: state_d = FS_IDLE;
         default: state_d = FS_IDLE;
      endcase
   end

   always_ff @(posedge fetch_unit_clock_in or posedge fetch_unit_reset_in) begin
      if (fetch_unit_reset_in) begin
         state_q <= FS_IDLE;
         addr_q  <= '0;
         ir_q    <= NOP_WORD;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         ir_q    <= ir_d;
         err_q   <= err_d;
      end
   end

   assign fetch_unit_pc_out         = pc;
   assign fetch_unit_ir_out         = ir_q;
   assign fetch_unit_ins_data_out   = ir_q[6:0];
   assign fetch_unit_fetch_done_out = (state_q == FS_DONE);
   assign fetch_unit_fetch_err_out  = err_q;
   assign fetch_unit_mem_req_out    = (state_q == FS_REQ);
   assign fetch_unit_mem_addr_out   = addr_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit; fetched words are queued when a fetch is
// issued and popped when the done pulse appears.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        pc_set;
   logic        ir_set;
   logic [1:0]  sel;
   logic [31:0] branch_t;
   logic [31:0] jump_t;
   logic [31:0] pc_out;
   logic [31:0] ir_out;
   logic [6:0]  ins_data;
   logic        done;
   logic        err;
   logic        req;
   logic [31:0] addr;
   logic        ack;
   logic [31:0] mdata;

   int total = 0;
   int bad   = 0;
   logic [31:0] exp_q[$];

   always #5 clk = ~clk;

   fetch_unit #(
      .RESET_VECTOR(32'h0000_0000),
      .NOP_WORD    (32'h0000_0013)
   ) dut (
      .fetch_unit_clock_in        (clk),
      .fetch_unit_reset_in        (rst),
      .fetch_unit_pc_set_val_in   (pc_set),
      .fetch_unit_ir_set_val_in   (ir_set),
      .fetch_unit_pc_mux_sel_in   (sel),
      .fetch_unit_branch_target_in(branch_t),
      .fetch_unit_jump_target_in  (jump_t),
      .fetch_unit_pc_out          (pc_out),
      .fetch_unit_ir_out          (ir_out),
      .fetch_unit_ins_data_out    (ins_data),
      .fetch_unit_fetch_done_out  (done),
      .fetch_unit_fetch_err_out   (err),
      .fetch_unit_mem_req_out     (req),
      .fetch_unit_mem_addr_out    (addr),
      .fetch_unit_mem_ack_in      (ack),
      .fetch_unit_mem_data_in     (mdata)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Bounded wait for the done pulse, then check the popped IR word and that the pulse is one cycle
   task automatic wait_done(input string tag);
      int unsigned n = 0;
      logic [31:0] e;
      while (done !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      chk({tag, "_done"}, {31'd0, done}, 32'd1);
      chk({tag, "_req_in_done"}, {31'd0, req}, 32'd0);
      chk({tag, "_sb_nonempty"}, (exp_q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk({tag, "_ir"}, ir_out, e);
      end
      // a new fetch request while in DONE must be dropped
      ir_set = 1'b1;
      tick();
      ir_set = 1'b0;
      chk({tag, "_done_one_cycle"}, {31'd0, done}, 32'd0);
      chk({tag, "_no_queued_req"}, {31'd0, req}, 32'd0);
   endtask

   initial begin
      rst = 1'b1; pc_set = 1'b0; ir_set = 1'b0; sel = 2'b00;
      branch_t = '0; jump_t = '0; ack = 1'b0; mdata = '0;
      #12;
      chk("rst_pc", pc_out, 32'h0);
      chk("rst_ir", ir_out, 32'h0000_0013);
      chk("rst_req", {31'd0, req}, 32'd0);
      chk("rst_addr", addr, 32'h0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_err", {31'd0, err}, 32'd0);
      rst = 1'b0;
      tick();
      chk("ins_data_nop", {25'd0, ins_data}, 32'h13);

      // sequential PC+4
      sel = 2'b00; pc_set = 1'b1;
      tick(); chk("pc_plus4_1", pc_out, 32'h4);
      tick(); chk("pc_plus4_2", pc_out, 32'h8);
      pc_set = 1'b0;
      tick(); chk("pc_hold_no_set", pc_out, 32'h8);

      // ack outside REQ is ignored
      ack = 1'b1; mdata = 32'hBAD0_BAD0;
      tick();
      ack = 1'b0;
      chk("idle_ack_ir", ir_out, 32'h0000_0013);

      // fetch at 0x8 with 3 wait states
      ir_set = 1'b1;
      exp_q.push_back(32'h00A0_0093);
      tick();
      ir_set = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("wait_req_%0d", i), {31'd0, req}, 32'd1);
         chk($sformatf("wait_addr_%0d", i), addr, 32'h8);
         tick();
      end
      ack = 1'b1; mdata = 32'h00A0_0093;
      chk("ack_cycle_req", {31'd0, req}, 32'd1);
      tick();
      ack = 1'b0; mdata = '0;
      wait_done("fetch8");
      chk("ins_data_addi", {25'd0, ins_data}, 32'h13);

      pc_set = 1'b1; sel = 2'b00;
      tick(); chk("pc_plus4_3", pc_out, 32'hC);
      tick(); chk("pc_plus4_4", pc_out, 32'h10);
      pc_set = 1'b0;

      // same-edge branch and fetch: fetch uses the old PC
      sel = 2'b01; branch_t = 32'h100; pc_set = 1'b1; ir_set = 1'b1;
      exp_q.push_back(32'h0050_0113);
      tick();
      ir_set = 1'b0;
      chk("same_edge_addr", addr, 32'h10);
      chk("same_edge_pc", pc_out, 32'h100);
      chk("same_edge_req", {31'd0, req}, 32'd1);
      sel = 2'b00;
      tick();
      pc_set = 1'b0;
      chk("pc_set_in_req_pc", pc_out, 32'h104);
      chk("pc_set_in_req_addr", addr, 32'h10);
      sel = 2'b11; pc_set = 1'b1;
      tick();
      pc_set = 1'b0;
      chk("pc_hold_sel11", pc_out, 32'h104);
      ack = 1'b1; mdata = 32'h0050_0113;
      tick();
      ack = 1'b0; mdata = '0;
      wait_done("fetch10");

      // misaligned jump target
      jump_t = 32'h102; sel = 2'b10; pc_set = 1'b1;
      tick();
      pc_set = 1'b0;
      chk("jump_pc", pc_out, 32'h102);
      ir_set = 1'b1;
      tick();
      ir_set = 1'b0;
      chk("misal_req", {31'd0, req}, 32'd0);
      chk("misal_err", {31'd0, err}, 32'd1);
      chk("misal_done", {31'd0, done}, 32'd1);
      chk("misal_ir", ir_out, 32'h0050_0113);
      tick();
      chk("misal_done_drop", {31'd0, done}, 32'd0);
      chk("err_sticky", {31'd0, err}, 32'd1);

      // reset during REQ abandons the fetch
      jump_t = 32'h200; sel = 2'b10; pc_set = 1'b1;
      tick();
      pc_set = 1'b0; ir_set = 1'b1;
      tick();
      ir_set = 1'b0;
      chk("pre_rst_req", {31'd0, req}, 32'd1);
      rst = 1'b1;
      #1;
      chk("async_rst_req", {31'd0, req}, 32'd0);
      chk("async_rst_ir", ir_out, 32'h0000_0013);
      chk("async_rst_pc", pc_out, 32'h0);
      chk("async_rst_addr", addr, 32'h0);
      chk("async_rst_err", {31'd0, err}, 32'd0);
      tick();
      rst = 1'b0;
      ack = 1'b1; mdata = 32'hDEAD_BEEF;
      tick();
      ack = 1'b0;
      chk("post_rst_ack_done", {31'd0, done}, 32'd0);
      chk("post_rst_ack_ir", ir_out, 32'h0000_0013);
      chk("post_rst_ack_req", {31'd0, req}, 32'd0);
      tick();
      chk("post_rst_done2", {31'd0, done}, 32'd0);

      // PC wrap
      jump_t = 32'hFFFF_FFFC; sel = 2'b10; pc_set = 1'b1;
      tick();
      chk("pc_top", pc_out, 32'hFFFF_FFFC);
      sel = 2'b00;
      tick();
      pc_set = 1'b0;
      chk("pc_wrap", pc_out, 32'h0);

      chk("sb_drained", exp_q.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
